// File: rtl/booth_r4_seq_mul.sv
// booth_r4_seq_mul: iterative signed multiplier, one modified radix-4 Booth
// digit per clock. The multiplicand is sign-extended to 2*WIDTH and shifted
// left by two each step. The multiplier window slides down an arithmetic
// right-shifted copy of {b, 1'b0}.
//
// Optional feature macro: BOOTH_SEQ_ZERO_SKIP_EN
//   When it is defined, RUN ends as soon as the unprocessed multiplier bits
//   are all zeros or all ones. Every remaining digit is then 0, so the
//   product is unchanged.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data while valid is high and ready is
// low. On the input side, in_ready is high in IDLE, and also in DONE when
// out_ready is high, so a new operand pair can enter on the same edge that
// the result is taken.
module booth_r4_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int N  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int KW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   m;
  logic [PW-1:0]   acc;
  logic [WIDTH:0]  q;
  logic [KW-1:0]   k;

  logic [PW-1:0]   term;
  logic            cin;
  logic [PW-1:0]   acc_next;
  logic [WIDTH:0]  q_next;
  logic            last_digit;
  logic            finish_run;
  logic            accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Recode the current 3-bit window into a Booth digit and form d*M.
  // Negative digits use the inverted term plus a carry-in at bit 0.
  always_comb begin
    term = '0;
    cin  = 1'b0;
    case (q[2:0])
      3'b001, 3'b010: term = m;
      3'b011:         term = m << 1;
      3'b100: begin
        term = ~(m << 1);
        cin  = 1'b1;
      end
      3'b101, 3'b110: begin
        term = ~m;
        cin  = 1'b1;
      end
      default:        term = '0;
    endcase
  end

  assign acc_next   = acc + term + {{(PW-1){1'b0}}, cin};
  // Arithmetic shift keeps the unprocessed bits sign-extended above the window.
  assign q_next     = {q[WIDTH], q[WIDTH], q[WIDTH:2]};
  assign last_digit = (k == KW'(N - 1));

`ifdef BOOTH_SEQ_ZERO_SKIP_EN
  // All remaining bits identical means every remaining digit is 0.
  assign finish_run = last_digit || (q_next == '0) || (q_next == '1);
`else
  assign finish_run = last_digit;
`endif

  // Control FSM and datapath registers. out_valid and busy are registered
  // copies of DONE and RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m         <= '0;
      q         <= '0;
      acc       <= '0;
      k         <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      m         <= {{WIDTH{a[WIDTH-1]}}, a};
      q         <= {b, 1'b0};
      acc       <= '0;
      k         <= '0;
      state     <= RUN;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          acc <= acc_next;
          m   <= m << 2;
          q   <= q_next;
          k   <= k + 1'b1;
          if (finish_run) begin
            product   <= acc_next;
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
